booth_mult_ctrl: RTL

//   Sequencing FSM for the radix-2 Booth multiplier datapath. Replaces hand-driven ld/ld_PP

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_mult_ctrl_if.sv | 29 ++
 rtl/booth_iter_counter.sv | 31 +++
 rtl/booth_mult_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
// State encoding, Booth pair decode values and a small state helper.
package booth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } booth_state_e;

    // {Q[0],Q[-1]} patterns that call for an accumulator update
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic logic state_is_busy(input booth_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/booth_mult_ctrl_if.sv
// Handshake and datapath-strobe bundle between requester/datapath and the Booth sequencer.
// The master side drives start and q_pair; the slave (sequencer) drives everything else.
interface booth_mult_ctrl_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic [1:0]       q_pair;
    logic             ld;
    logic             ld_PP;
    logic             add_en;
    logic             sub_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter;

    modport master (
        output start, q_pair,
        input  ld, ld_PP, add_en, sub_en, shift_en, busy, done, iter
    );

    modport slave (
        input  start, q_pair,
        output ld, ld_PP, add_en, sub_en, shift_en, busy, done, iter
    );

endinterface

// File: rtl/booth_iter_counter.sv
// Remaining-iteration counter: loaded with WIDTH, decremented once per shift,
// flags the final iteration so the sequencer can leave the EVAL/SHIFT loop.
module booth_iter_counter #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_iter,
    output logic             o_last
);

    logic [CNT_W-1:0] r_iter;

    // Saturates at zero so a stray decrement can never wrap the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter <= '0;
        end else if (i_load) begin
            r_iter <= CNT_W'(WIDTH);
        end else if (i_dec && (r_iter != '0)) begin
            r_iter <= r_iter - CNT_W'(1);
        end
    end

    assign o_iter = r_iter;
    assign o_last = (r_iter == CNT_W'(1));

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath: start/busy/done handshake
// in front, one-hot ld/ld_PP/add/sub/shift strobes towards the datapath.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    booth_mult_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    booth_state_e     r_state;
    booth_state_e     w_state_next;
    logic             w_ld;
    logic             w_ld_pp;
    logic             w_add_en;
    logic             w_sub_en;
    logic             w_shift_en;
    logic             w_cnt_load;
    logic             w_last;
    logic [CNT_W-1:0] w_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // q_pair is only looked at in EVAL, so an unknown pair elsewhere cannot reach a strobe
    always_comb begin
        w_state_next = r_state;
        w_ld         = 1'b0;
        w_ld_pp      = 1'b0;
        w_add_en     = 1'b0;
        w_sub_en     = 1'b0;
        w_shift_en   = 1'b0;
        w_cnt_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ld         = 1'b1;
                w_state_next = ST_INIT;
            end
            ST_INIT: begin
                w_ld_pp      = 1'b1;
                w_cnt_load   = 1'b1;
                w_state_next = ST_EVAL;
            end
            ST_EVAL: begin
                if (bus.q_pair == BOOTH_SUB) begin
                    w_sub_en = 1'b1;
                end else if (bus.q_pair == BOOTH_ADD) begin
                    w_add_en = 1'b1;
                end
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift_en   = 1'b1;
                w_state_next = w_last ? ST_DONE : ST_EVAL;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    booth_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_cnt_load),
        .i_dec  (w_shift_en),
        .o_iter (w_iter),
        .o_last (w_last)
    );

    assign bus.ld       = w_ld;
    assign bus.ld_PP    = w_ld_pp;
    assign bus.add_en   = w_add_en;
    assign bus.sub_en   = w_sub_en;
    assign bus.shift_en = w_shift_en;
    assign bus.busy     = state_is_busy(r_state);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.iter     = w_iter;

endmodule
